paddle_ctrl: RTL
================

# paddle_ctrl

Paddle movement controller for the Breakout game. It consumes the two debounced button levels (left, right) and turns them into paddle position updates, paced by the frame tick. A press moves the paddle one step at once. A held button auto-repeats after a delay. The position is clamped to the playfield. The block sits between the button debouncer and the renderer/collision logic, which read `paddle_x`.

## Interface
Parameters:
- `SCREEN_W`, 640: playfield width in pixels.
- `PADDLE_W`, 64: paddle width in pixels. `MAX_X = SCREEN_W - PADDLE_W` (576).
- `STEP`, 8: pixels moved per step. Must be ≥1 and < MAX_X.
- `X_INIT`, 288: reset and recentre position. Must be ≤ MAX_X.
- `DELAY`, 15: ticks a button is held before auto-repeat starts. Must be ≥1.
- `RATE`, 2: ticks between auto-repeat steps. Must be ≥1.
- `XW`, 10: width of the position field.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. Synchronous and active-high.
- `tick`, in, 1: frame strobe, one `clk` wide. All decisions are made on tick cycles.
- `en`, in, 1: game running. When low, movement is frozen.
- `recentre`, in, 1: one-cycle pulse that returns the paddle to `X_INIT`.
- `btn_l`, in, 1: debounced left button level.
- `btn_r`, in, 1: debounced right button level.
- `paddle_x`, out, XW: left edge of the paddle, 0..MAX_X.
- `at_left`, out, 1: high when `paddle_x == 0`.
- `at_right`, out, 1: high when `paddle_x == MAX_X`.
- `moving`, out, 1: one-cycle pulse, high in the cycle after a step changes `paddle_x`.

## Operation
- Direction decode, evaluated on tick cycles only:
  - L = `btn_l & ~btn_r`.
  - R = `btn_r & ~btn_l`.
  - NONE = neither button, or both buttons.
- States:
  - IDLE: paddle not moving.
  - HOLD: waiting out `DELAY` before auto-repeat.
  - REPEAT: stepping every `RATE` ticks.
  - Registered with the state: last direction `dir` and tick counter `cnt`.
- IDLE, on tick with L or R:
  - Step once in that direction.
  - Set `dir`, load `cnt = DELAY - 1`, go to HOLD.
- HOLD, on tick with the same direction:
  - If `cnt == 0`: step, load `cnt = RATE - 1`, go to REPEAT.
  - Otherwise decrement `cnt`.
- REPEAT, on tick with the same direction:
  - If `cnt == 0`: step and reload `cnt = RATE - 1`.
  - Otherwise decrement `cnt`.
- HOLD or REPEAT, on tick with the opposite single direction:
  - Treat as a fresh press: step immediately, update `dir`, load `cnt = DELAY - 1`, go to HOLD.
- Any state, on tick with NONE: go to IDLE with no step.
- Step arithmetic, computed at XW+1 bits to avoid wrap:
  - Right: `paddle_x + STEP`, clamped to MAX_X.
  - Left: clamped to 0 if `paddle_x < STEP`, otherwise `paddle_x - STEP`.
  - A step that leaves `paddle_x` unchanged (already at the limit) keeps the state transition but does not pulse `moving`.
- `en` low:
  - State forced to IDLE and `cnt` cleared.
  - `paddle_x` held and ticks ignored.
  - When `en` rises with a button already held, the next tick counts as a fresh press.
- `recentre`:
  - Sets `paddle_x = X_INIT` and forces IDLE.
  - Has priority over a coincident tick step.
  - `moving` is not pulsed.
- `rst`:
  - `paddle_x = X_INIT`, state IDLE, `cnt = 0`, `dir = L`, `moving = 0`.
  - `at_left` and `at_right` follow from X_INIT (0 and 0 at defaults).
  - Reset mid-HOLD or mid-REPEAT abandons the sequence. The first tick after reset with a button held is a fresh press.

## Timing
- `paddle_x`, state and `cnt` update at the clock edge that ends the tick cycle. The new position is visible one cycle after `tick`.
- `moving` is high for exactly that one cycle.
- `at_left` and `at_right` are combinational from the registered `paddle_x`, so they have no extra latency.
- Button changes between ticks are invisible. Only levels sampled on tick cycles matter.
- Priority in a single cycle, highest first: `rst`, `recentre`, `en` low, tick logic.
- Step cadence for a continuous hold starting at tick 0 (defaults):
  - Steps at ticks 0, 15, 17, 19, and so on.
  - In general: 0, DELAY, then every RATE ticks.

## Structure
- The shared package `breakout_pkg` holds:
  - `SCREEN_W` and `PADDLE_W`, also used by the renderer and collision logic.
  - The `paddle_state_t` enum (IDLE, HOLD, REPEAT).
  - The `dir_t` type (L, R).
- One natural sub-module, `paddle_step`: combinational next-position logic with clamping. It takes `paddle_x` and `dir`, and returns the new x plus a changed flag. It can be verified standalone at the limits.
- The FSM and the counter stay in `paddle_ctrl`.

## Test plan
All scenarios use default parameters.
- Reset, then tick with no buttons → `paddle_x` = 288, `moving` never pulses, `at_left` = `at_right` = 0.
- `btn_r` held for 20 ticks → steps at ticks 0, 15, 17, 19. `paddle_x` goes 296, 304, 312, 320, and `moving` pulses four times, each one cycle after its tick.
- `btn_l` held from `paddle_x` = 4 → first step clamps to 0 and `at_left` rises. Later steps leave x at 0 with no `moving` pulse. Same check on the right at 576 with `at_right`.
- Hold `btn_r` for 16 ticks, then switch to `btn_l` → immediate left step on the switch tick, and the next left step comes 15 ticks later.
- Both buttons held, and pulses of `btn_r` narrower than a tick period that fall between ticks → no movement, state stays IDLE.
- `rst` asserted in REPEAT, and `recentre` coincident with a step tick → both give `paddle_x` = 288 with no `moving` pulse. After `rst`, the first held-button tick steps immediately.

Source files
------------

// File: rtl/breakout_pkg.sv
// Shared Breakout definitions: playfield geometry and paddle FSM types.
// Used by the paddle controller, renderer and collision logic.
package breakout_pkg;

   localparam int SCREEN_W = 640;
   localparam int PADDLE_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } paddle_state_t;

   typedef enum logic {
      DIR_L = 1'b0,
      DIR_R = 1'b1
   } dir_t;

endpackage

// File: rtl/paddle_step.sv
// Combinational next-position logic for one paddle step with clamping.
// Ports: i_x current x, i_dir step direction, o_x next x, o_changed x moved.
module paddle_step
   import breakout_pkg::*;
#(
   parameter int XW    = 10,
   parameter int MAX_X = 576,
   parameter int STEP  = 8
) (
   input  logic [XW-1:0] i_x,
   input  dir_t          i_dir,
   output logic [XW-1:0] o_x,
   output logic          o_changed
);

   logic [XW:0] w_ext;
   logic [XW:0] w_sum;

   // One extra bit of headroom so the sum cannot wrap before clamping.
   always_comb begin
      w_ext = {1'b0, i_x};
      w_sum = w_ext + (XW+1)'(STEP);
      o_x   = i_x;
      if (i_dir == DIR_R) begin
         if (w_sum > (XW+1)'(MAX_X)) begin
            o_x = XW'(MAX_X);
         end else begin
            o_x = w_sum[XW-1:0];
         end
      end else begin
         if (w_ext < (XW+1)'(STEP)) begin
            o_x = '0;
         end else begin
            o_x = XW'(w_ext - (XW+1)'(STEP));
         end
      end
      o_changed = (o_x != i_x);
   end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle movement controller: button levels to clamped paddle position,
// press steps at once, hold auto-repeats after DELAY ticks every RATE ticks.
// Ports: clk, rst, tick, en, recentre, btn_l, btn_r in;
//        paddle_x, at_left, at_right, moving out.
module paddle_ctrl
   import breakout_pkg::*;
#(
   parameter int SCREEN_W = breakout_pkg::SCREEN_W,
   parameter int PADDLE_W = breakout_pkg::PADDLE_W,
   parameter int STEP     = 8,
   parameter int X_INIT   = 288,
   parameter int DELAY    = 15,
   parameter int RATE     = 2,
   parameter int XW       = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          en,
   input  logic          recentre,
   input  logic          btn_l,
   input  logic          btn_r,
   output logic [XW-1:0] paddle_x,
   output logic          at_left,
   output logic          at_right,
   output logic          moving
);

   localparam int MAX_X = SCREEN_W - PADDLE_W;
   localparam int CMAX  = (DELAY > RATE) ? DELAY : RATE;
   localparam int CW    = (CMAX < 2) ? 1 : $clog2(CMAX);

   paddle_state_t r_state;
   dir_t          r_dir;
   logic [CW-1:0] r_cnt;
   logic [XW-1:0] r_x;
   logic          r_moving;

   logic          w_l;
   logic          w_r;
   dir_t          w_dir;
   logic [XW-1:0] w_x_nxt;
   logic          w_changed;

   assign w_l   = btn_l & ~btn_r;
   assign w_r   = btn_r & ~btn_l;
   assign w_dir = w_r ? DIR_R : DIR_L;

   // Held direction equals r_dir whenever we continue a sequence,
   // so the decoded direction always drives the stepper.
   paddle_step #(
      .XW    (XW),
      .MAX_X (MAX_X),
      .STEP  (STEP)
   ) u_step (
      .i_x       (r_x),
      .i_dir     (w_dir),
      .o_x       (w_x_nxt),
      .o_changed (w_changed)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_x      <= XW'(X_INIT);
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_dir    <= DIR_L;
         r_moving <= 1'b0;
      end else begin
         r_moving <= 1'b0;
         if (recentre) begin
            r_x     <= XW'(X_INIT);
            r_state <= ST_IDLE;
            r_cnt   <= '0;
         end else if (!en) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
         end else if (tick) begin
            if (!(w_l | w_r)) begin
               r_state <= ST_IDLE;
            end else if (r_state == ST_IDLE || w_dir != r_dir) begin
               // Fresh press, including a reversal mid-sequence.
               r_x      <= w_x_nxt;
               r_moving <= w_changed;
               r_dir    <= w_dir;
               r_cnt    <= CW'(DELAY - 1);
               r_state  <= ST_HOLD;
            end else if (r_cnt == '0) begin
               r_x      <= w_x_nxt;
               r_moving <= w_changed;
               r_cnt    <= CW'(RATE - 1);
               r_state  <= ST_REPEAT;
            end else begin
               r_cnt <= r_cnt - CW'(1);
            end
         end
      end
   end

   assign paddle_x = r_x;
   assign moving   = r_moving;
   assign at_left  = (r_x == '0);
   assign at_right = (r_x == XW'(MAX_X));

endmodule
